// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - ALU operation codes, RV32I opcode/funct7 constants, decoded command type
package alu_pkg;

  typedef enum logic [4:0] {
    ALU_NONE = 5'd0,
    ALU_ADD  = 5'd1,
    ALU_SUB  = 5'd2,
    ALU_AND  = 5'd3,
    ALU_OR   = 5'd4,
    ALU_XOR  = 5'd5,
    ALU_SLT  = 5'd6,
    ALU_SLTU = 5'd7,
    ALU_SRA  = 5'd8,
    ALU_SRL  = 5'd9,
    ALU_SLL  = 5'd10,
    ALU_ADDI = 5'd11,
    ALU_ANDI = 5'd12,
    ALU_ORI  = 5'd13,
    ALU_XORI = 5'd14,
    ALU_SLTI = 5'd15,
    ALU_SLTIU = 5'd16,
    ALU_SRAI = 5'd17,
    ALU_SRLI = 5'd18,
    ALU_SLLI = 5'd19
  } alu_op_t;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic [4:0]  alu_op;
    logic [31:0] alu_in1;
    logic [31:0] alu_in2;
    logic [4:0]  rd;
    logic        illegal;
  } alu_cmd_t;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } stage_state_t;

endpackage

// File: rtl/alu_op_dec.sv
// rtl/alu_op_dec.sv - combinational RV32I R/I-type ALU decode with operand selection
module alu_op_dec
  import alu_pkg::*;
(
  input  logic [31:0] instr,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  output logic [4:0]  alu_op,
  output logic [31:0] alu_in1,
  output logic [31:0] alu_in2,
  output logic [4:0]  rd,
  output logic        illegal
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  alu_op_t    op;
  logic       imm_shift;
  logic       unused_rs_idx;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign rd     = instr[11:7];
  // source register indices are resolved by the register file upstream
  assign unused_rs_idx = ^instr[19:15];

  always_comb begin
    op        = ALU_NONE;
    imm_shift = 1'b0;
    if (opcode == OP_R) begin
      case (funct3)
        3'b000: begin
          if (funct7 == F7_ZERO)     op = ALU_ADD;
          else if (funct7 == F7_ALT) op = ALU_SUB;
        end
        3'b001: if (funct7 == F7_ZERO) op = ALU_SLL;
        3'b010: if (funct7 == F7_ZERO) op = ALU_SLT;
        3'b011: if (funct7 == F7_ZERO) op = ALU_SLTU;
        3'b100: if (funct7 == F7_ZERO) op = ALU_XOR;
        3'b101: begin
          if (funct7 == F7_ZERO)     op = ALU_SRL;
          else if (funct7 == F7_ALT) op = ALU_SRA;
        end
        3'b110: if (funct7 == F7_ZERO) op = ALU_OR;
        default: if (funct7 == F7_ZERO) op = ALU_AND;
      endcase
    end else if (opcode == OP_I) begin
      case (funct3)
        3'b000: op = ALU_ADDI;
        3'b010: op = ALU_SLTI;
        3'b011: op = ALU_SLTIU;
        3'b100: op = ALU_XORI;
        3'b110: op = ALU_ORI;
        3'b111: op = ALU_ANDI;
        3'b001: begin
          imm_shift = 1'b1;
          if (funct7 == F7_ZERO) op = ALU_SLLI;
        end
        default: begin
          imm_shift = 1'b1;
          if (funct7 == F7_ZERO)     op = ALU_SRLI;
          else if (funct7 == F7_ALT) op = ALU_SRAI;
        end
      endcase
    end
  end

  // illegal encodings carry zeroed operands so downstream never sees stale data
  always_comb begin
    alu_in1 = 32'd0;
    alu_in2 = 32'd0;
    illegal = (op == ALU_NONE);
    if (!illegal) begin
      alu_in1 = rs1_data;
      if (opcode == OP_R)
        alu_in2 = rs2_data;
      else if (imm_shift)
        alu_in2 = {27'd0, instr[24:20]};
      else
        alu_in2 = {{20{instr[31]}}, instr[31:20]};
    end
  end

  assign alu_op = op;

endmodule

// File: rtl/alu_decode_stage.sv
// rtl/alu_decode_stage.sv - decode stage with output register plus skid entry, registered in_ready
module alu_decode_stage
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  alu_op,
  output logic [31:0] alu_in1,
  output logic [31:0] alu_in2,
  output logic [4:0]  rd,
  output logic        illegal
);

  alu_cmd_t     dec_cmd;
  alu_cmd_t     out_q;
  alu_cmd_t     skid_q;
  stage_state_t state_q, state_d;
  logic         in_ready_q;
  logic         in_fire, out_fire;
  logic         ld_out_in, ld_out_skid, ld_skid;

  alu_op_dec u_dec (
    .instr    (instr),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .alu_op   (dec_cmd.alu_op),
    .alu_in1  (dec_cmd.alu_in1),
    .alu_in2  (dec_cmd.alu_in2),
    .rd       (dec_cmd.rd),
    .illegal  (dec_cmd.illegal)
  );

  assign in_fire  = in_valid & in_ready_q;
  assign out_fire = out_valid & out_ready;

  always_comb begin
    state_d     = state_q;
    ld_out_in   = 1'b0;
    ld_out_skid = 1'b0;
    ld_skid     = 1'b0;
    case (state_q)
      S_EMPTY: begin
        if (in_fire) begin
          ld_out_in = 1'b1;
          state_d   = S_ONE;
        end
      end
      S_ONE: begin
        if (in_fire && out_fire) begin
          ld_out_in = 1'b1;
        end else if (in_fire) begin
          ld_skid = 1'b1;
          state_d = S_TWO;
        end else if (out_fire) begin
          state_d = S_EMPTY;
        end
      end
      S_TWO: begin
        if (out_fire) begin
          ld_out_skid = 1'b1;
          state_d     = S_ONE;
        end
      end
      default: state_d = S_EMPTY;
    endcase
  end

  // in_ready comes from a flop so out_ready never reaches it combinationally
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != S_TWO);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q  <= '0;
      skid_q <= '0;
    end else begin
      if (ld_out_in)
        out_q <= dec_cmd;
      else if (ld_out_skid)
        out_q <= skid_q;
      if (ld_skid)
        skid_q <= dec_cmd;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != S_EMPTY);
  assign alu_op    = out_q.alu_op;
  assign alu_in1   = out_q.alu_in1;
  assign alu_in2   = out_q.alu_in2;
  assign rd        = out_q.rd;
  assign illegal   = out_q.illegal;

endmodule

// File: tb/tb_alu_decode_stage.sv
// tb/tb_alu_decode_stage.sv - directed and randomized-handshake bench for alu_decode_stage
module tb_alu_decode_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] instr = 32'd0;
  logic [31:0] rs1_data = 32'd0;
  logic [31:0] rs2_data = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [4:0]  alu_op;
  logic [31:0] alu_in1;
  logic [31:0] alu_in2;
  logic [4:0]  rd;
  logic        illegal;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [4:0]  op;
    logic [31:0] in1;
    logic [31:0] in2;
    logic [4:0]  rd;
    logic        ill;
  } vec_t;

  localparam int NV = 23;
  vec_t vecs[NV];

  always #5 clk = ~clk;

  alu_decode_stage dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .instr     (instr),
    .rs1_data  (rs1_data),
    .rs2_data  (rs2_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .alu_op    (alu_op),
    .alu_in1   (alu_in1),
    .alu_in2   (alu_in2),
    .rd        (rd),
    .illegal   (illegal)
  );

  function automatic vec_t mk(logic [31:0] i, logic [31:0] a, logic [31:0] b, int op,
                              logic [31:0] x, logic [31:0] y, int r, bit il);
    vec_t v;
    v.instr = i; v.rs1 = a; v.rs2 = b; v.op = op[4:0];
    v.in1 = x; v.in2 = y; v.rd = r[4:0]; v.ill = il;
    return v;
  endfunction

  task automatic init_vecs();
    vecs[0]  = mk(32'h002081B3, 32'd5,         32'd7,         1,  32'd5,         32'd7,         3,  0);
    vecs[1]  = mk(32'hFFF00093, 32'h10,        32'h99,        11, 32'h10,        32'hFFFFFFFF,  1,  0);
    vecs[2]  = mk(32'h40415113, 32'h80000000,  32'h99,        17, 32'h80000000,  32'd4,         2,  0);
    vecs[3]  = mk(32'h40208133, 32'h30,        32'h10,        2,  32'h30,        32'h10,        2,  0);
    vecs[4]  = mk(32'h4020D133, 32'hF0000000,  32'd3,         8,  32'hF0000000,  32'd3,         2,  0);
    vecs[5]  = mk(32'h022081B3, 32'h55,        32'h66,        0,  32'd0,         32'd0,         3,  1);
    vecs[6]  = mk(32'h007372B3, 32'hFF00FF00,  32'h0F0F0F0F,  3,  32'hFF00FF00,  32'h0F0F0F0F,  5,  0);
    vecs[7]  = mk(32'h41F21213, 32'h1234,      32'd0,         0,  32'd0,         32'd0,         4,  1);
    vecs[8]  = mk(32'h01F21213, 32'h1234,      32'hDEAD,      19, 32'h1234,      32'd31,        4,  0);
    vecs[9]  = mk(32'h7FF43493, 32'h800,       32'hDEAD,      16, 32'h800,       32'h7FF,       9,  0);
    vecs[10] = mk(32'h0000A083, 32'h44,        32'h55,        0,  32'd0,         32'd0,         1,  1);
    vecs[11] = mk(32'h00C5B533, 32'd1,         32'd2,         7,  32'd1,         32'd2,         10, 0);
    vecs[12] = mk(32'h80014093, 32'hCAFE,      32'hBEEF,      14, 32'hCAFE,      32'hFFFFF800,  1,  0);
    vecs[13] = mk(32'h0000D093, 32'h77,        32'h88,        18, 32'h77,        32'd0,         1,  0);
    vecs[14] = mk(32'h003160B3, 32'h11,        32'h22,        4,  32'h11,        32'h22,        1,  0);
    vecs[15] = mk(32'h003140B3, 32'h11,        32'h22,        5,  32'h11,        32'h22,        1,  0);
    vecs[16] = mk(32'h003120B3, 32'h11,        32'h22,        6,  32'h11,        32'h22,        1,  0);
    vecs[17] = mk(32'h003150B3, 32'h11,        32'h22,        9,  32'h11,        32'h22,        1,  0);
    vecs[18] = mk(32'h003110B3, 32'h11,        32'h22,        10, 32'h11,        32'h22,        1,  0);
    vecs[19] = mk(32'h00F17093, 32'h11,        32'h22,        12, 32'h11,        32'h0F,        1,  0);
    vecs[20] = mk(32'h00F16093, 32'h11,        32'h22,        13, 32'h11,        32'h0F,        1,  0);
    vecs[21] = mk(32'hFFF12093, 32'h11,        32'h22,        15, 32'h11,        32'hFFFFFFFF,  1,  0);
    vecs[22] = mk(32'h403110B3, 32'h11,        32'h22,        0,  32'd0,         32'd0,         1,  1);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(int idx);
    instr    = vecs[idx].instr;
    rs1_data = vecs[idx].rs1;
    rs2_data = vecs[idx].rs2;
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #2;
    n_cmp++;
    if ({out_valid, in_ready, alu_op, alu_in1, alu_in2, rd, illegal} !== {1'b0, 1'b1, 5'd0, 32'd0, 32'd0, 5'd0, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_state: got v=%b r=%b op=%0d in1=%h in2=%h rd=%0d ill=%b, want v=0 r=1 others 0",
               out_valid, in_ready, alu_op, alu_in1, alu_in2, rd, illegal);
    end
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_decode();
    out_ready = 1'b1;
    for (int i = 0; i < NV; i++) begin
      drive(i);
      in_valid = 1'b1;
      tick();
      n_cmp++;
      if ({out_valid, alu_op, alu_in1, alu_in2, rd, illegal} !==
          {1'b1, vecs[i].op, vecs[i].in1, vecs[i].in2, vecs[i].rd, vecs[i].ill}) begin
        n_bad++;
        $display("FAIL decode_%0d instr=%h: got v=%b op=%0d in1=%h in2=%h rd=%0d ill=%b, want v=1 op=%0d in1=%h in2=%h rd=%0d ill=%b",
                 i, vecs[i].instr, out_valid, alu_op, alu_in1, alu_in2, rd, illegal,
                 vecs[i].op, vecs[i].in1, vecs[i].in2, vecs[i].rd, vecs[i].ill);
      end
    end
    in_valid = 1'b0;
    tick();
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL decode_drain: out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_back_to_back();
    int seq[3] = '{14, 15, 16};
    int k = 0;
    int got = 0;
    bit fire_in, fire_out;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int c = 0; c < 3; c++) begin
      drive(seq[k]);
      fire_in = in_ready;
      tick();
      if (fire_in) k++;
      n_cmp++;
      if ({out_valid, alu_op, alu_in1} !== {1'b1, vecs[14].op, vecs[14].in1}) begin
        n_bad++;
        $display("FAIL stall_hold_%0d: got v=%b op=%0d in1=%h, want v=1 op=%0d in1=%h",
                 c, out_valid, alu_op, alu_in1, vecs[14].op, vecs[14].in1);
      end
    end
    n_cmp++;
    if (k !== 2 || in_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL stall_accept: accepted=%0d in_ready=%b, want accepted=2 in_ready=0", k, in_ready);
    end
    out_ready = 1'b1;
    for (int c = 0; c < 10 && got < 3; c++) begin
      if (k < 3) drive(seq[k]);
      else in_valid = 1'b0;
      if (out_valid) begin
        n_cmp++;
        if ({alu_op, alu_in2, rd} !== {vecs[seq[got]].op, vecs[seq[got]].in2, vecs[seq[got]].rd}) begin
          n_bad++;
          $display("FAIL drain_order_%0d: got op=%0d in2=%h rd=%0d, want op=%0d in2=%h rd=%0d",
                   got, alu_op, alu_in2, rd, vecs[seq[got]].op, vecs[seq[got]].in2, vecs[seq[got]].rd);
        end
      end
      fire_in  = in_valid & in_ready;
      fire_out = out_valid & out_ready;
      tick();
      if (fire_in) k++;
      if (fire_out) got++;
    end
    in_valid = 1'b0;
    n_cmp++;
    if (got !== 3 || out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL drain_count: beats_out=%0d out_valid=%b, want 3 and 0", got, out_valid);
    end
  endtask

  task automatic test_random();
    int q[$];
    int sent = 0;
    int got = 0;
    int cyc = 0;
    int errs = 0;
    int idx;
    bit fire_in, fire_out;
    while (got < 10000 && cyc < 60000 && errs < 10) begin
      n_cmp++;
      if (out_valid !== (q.size() != 0) || in_ready !== (q.size() < 2)) begin
        n_bad++; errs++;
        $display("FAIL rand_flags cyc=%0d: out_valid=%b in_ready=%b, want %b %b",
                 cyc, out_valid, in_ready, q.size() != 0, q.size() < 2);
      end
      if (out_valid && q.size() > 0) begin
        n_cmp++;
        if ({alu_op, alu_in1, alu_in2, rd, illegal} !==
            {vecs[q[0]].op, vecs[q[0]].in1, vecs[q[0]].in2, vecs[q[0]].rd, vecs[q[0]].ill}) begin
          n_bad++; errs++;
          $display("FAIL rand_data beat=%0d: got op=%0d in1=%h in2=%h rd=%0d ill=%b, want op=%0d in1=%h in2=%h rd=%0d ill=%b",
                   got, alu_op, alu_in1, alu_in2, rd, illegal,
                   vecs[q[0]].op, vecs[q[0]].in1, vecs[q[0]].in2, vecs[q[0]].rd, vecs[q[0]].ill);
        end
      end
      idx = $urandom_range(0, NV - 1);
      drive(idx);
      in_valid  = (sent < 10000) && ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      fire_in  = in_valid & in_ready;
      fire_out = out_valid & out_ready;
      tick();
      cyc++;
      if (fire_out && q.size() > 0) begin
        void'(q.pop_front());
        got++;
      end
      if (fire_in) begin
        q.push_back(idx);
        sent++;
      end
    end
    in_valid = 1'b0;
    n_cmp++;
    if (got !== 10000) begin
      n_bad++;
      $display("FAIL rand_beats: delivered=%0d want 10000 (cycles=%0d)", got, cyc);
    end
  endtask

  task automatic test_reset_in_two();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    drive(0);
    tick();
    drive(1);
    tick();
    in_valid = 1'b0;
    n_cmp++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL two_full: in_ready=%b out_valid=%b, want 0 1", in_ready, out_valid);
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({out_valid, in_ready, alu_op, alu_in1, alu_in2, rd, illegal} !== {1'b0, 1'b1, 5'd0, 32'd0, 32'd0, 5'd0, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_async: got v=%b r=%b op=%0d in1=%h in2=%h rd=%0d ill=%b, want v=0 r=1 others 0",
               out_valid, in_ready, alu_op, alu_in1, alu_in2, rd, illegal);
    end
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    drive(2);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL post_reset_idle: out_valid=%b want 0", out_valid);
    end
    tick();
    in_valid = 1'b0;
    n_cmp++;
    if ({out_valid, alu_op, alu_in2, rd} !== {1'b1, vecs[2].op, vecs[2].in2, vecs[2].rd}) begin
      n_bad++;
      $display("FAIL post_reset_beat: got v=%b op=%0d in2=%h rd=%0d, want v=1 op=%0d in2=%h rd=%0d",
               out_valid, alu_op, alu_in2, rd, vecs[2].op, vecs[2].in2, vecs[2].rd);
    end
    tick();
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL post_reset_drain: out_valid=%b want 0 (no duplicate)", out_valid);
    end
  endtask

  initial begin
    init_vecs();
    test_reset();
    test_decode();
    test_back_to_back();
    test_random();
    test_reset_in_two();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
